// File: rtl/mmio_output_buffer_if.sv
// Port A bus and host-side byte stream used by mmio_output_buffer.
// The master side is the core and the host consumer. The slave side is the buffer.
interface mmio_output_buffer_if;
    // Port A request, shared with the unified memory
    logic        en_a;
    logic [3:0]  we_a;
    logic [31:0] addr_a;
    logic [31:0] din_a;

    // Read return, muxed by the core over the memory's dout_a
    logic        mmio_rd_sel;
    logic [31:0] mmio_rdata;

    // Output byte stream towards the host
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output en_a,
        output we_a,
        output addr_a,
        output din_a,
        output out_ready,
        input  mmio_rd_sel,
        input  mmio_rdata,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  en_a,
        input  we_a,
        input  addr_a,
        input  din_a,
        input  out_ready,
        output mmio_rd_sel,
        output mmio_rdata,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/mmio_output_buffer.sv
// Memory-mapped output byte FIFO on port A.
// Stores to DATA (0x8000_0004) enqueue din_a[7:0].
// Loads of AVAIL (0x8000_0000) return the free space one edge later.
// Buffered bytes drain over a valid/ready byte stream.
// Pushes arriving while the FIFO is full with no pop are dropped and counted.
module mmio_output_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mmio_output_buffer_if.slave  bus,
    output logic [7:0]           drop_count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [31:0]      ADDR_AVAIL = 32'h8000_0000;
    localparam logic [31:0]      ADDR_DATA  = 32'h8000_0004;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    // Storage and state
    logic [7:0]        mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [7:0]        drop_cnt_r;
    logic              rd_sel_r;
    logic [31:0]       rdata_r;

    // Decode and handshake terms
    logic              hit_avail_s;
    logic              hit_data_s;
    logic              push_req_s;
    logic              rd_req_s;
    logic              empty_s;
    logic              full_s;
    logic              valid_s;
    logic              pop_s;
    logic              push_ok_s;
    logic              drop_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [CNT_W-1:0]  free_s;
    logic [7:0]        head_s;

    // Only the low byte of a DATA store is buffered.
    logic              din_unused_s;
    assign din_unused_s = ^bus.din_a[31:8];

    // Full 32-bit address decode of the two registers and the request type
    always_comb begin
        hit_avail_s = 1'b0;
        hit_data_s  = 1'b0;
        push_req_s  = 1'b0;
        rd_req_s    = 1'b0;
        if (bus.addr_a == ADDR_AVAIL) begin
            hit_avail_s = 1'b1;
        end else if (bus.addr_a == ADDR_DATA) begin
            hit_data_s = 1'b1;
        end else begin
            hit_avail_s = 1'b0;
            hit_data_s  = 1'b0;
        end
        if (bus.en_a) begin
            push_req_s = hit_data_s && (bus.we_a != 4'b0000);
            rd_req_s   = hit_avail_s && (bus.we_a == 4'b0000);
        end else begin
            push_req_s = 1'b0;
            rd_req_s   = 1'b0;
        end
    end

    // FIFO status and push acceptance. A full FIFO accepts a push only when a pop frees the slot in the same cycle.
    always_comb begin
        empty_s   = (count_r == CNT_ZERO);
        full_s    = (count_r == DEPTH_C);
        valid_s   = !empty_s;
        pop_s     = valid_s && bus.out_ready;
        push_ok_s = 1'b0;
        drop_s    = 1'b0;
        if (full_s) begin
            push_ok_s = push_req_s && pop_s;
            drop_s    = push_req_s && !pop_s;
        end else begin
            push_ok_s = push_req_s;
            drop_s    = 1'b0;
        end
    end

    // Next occupancy: count + push_ok - pop
    always_comb begin
        count_nxt_s = count_r;
        if (push_ok_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (!push_ok_s && pop_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Free space as seen before this edge's push/pop
    always_comb begin
        free_s = DEPTH_C - count_r;
    end

    // Head byte is masked to zero while empty, so stale storage never shows and a push into an empty FIFO never bypasses
    always_comb begin
        head_s = 8'h00;
        if (valid_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = 8'h00;
        end
    end

    // Byte storage: no reset, since contents are only visible through count
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= bus.din_a[7:0];
        end
    end

    // Pointers and occupancy. Reset discards buffered bytes immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Saturating count of pushes discarded because the FIFO was full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_r <= 8'h00;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'h01;
        end
    end

    // AVAIL read return. rd_sel lasts exactly one cycle; rdata holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
        end else begin
            rd_sel_r <= rd_req_s;
            if (rd_req_s) begin
                rdata_r <= 32'(free_s);
            end
        end
    end

    assign bus.mmio_rd_sel = rd_sel_r;
    assign bus.mmio_rdata  = rdata_r;
    assign bus.out_valid   = valid_s;
    assign bus.out_data    = head_s;
    assign drop_count      = drop_cnt_r;

endmodule

// File: tb/tb_mmio_output_buffer.sv
// Directed bench for mmio_output_buffer: inputs change on the falling edge, outputs are checked on the falling edge.
module tb_mmio_output_buffer;

    localparam logic [31:0] AVAIL = 32'h8000_0000;
    localparam logic [31:0] DATA  = 32'h8000_0004;

    logic       clk;
    logic       reset_n;
    logic [7:0] drop_count;
    int         total;
    int         bad;

    mmio_output_buffer_if bus ();

    mmio_output_buffer #(.DEPTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        bus.en_a   = 1'b1;
        bus.we_a   = we;
        bus.addr_a = a;
        bus.din_a  = d;
        step();
        bus.en_a   = 1'b0;
        bus.we_a   = 4'b0000;
    endtask

    task automatic read_addr(input logic [31:0] a);
        bus.en_a   = 1'b1;
        bus.we_a   = 4'b0000;
        bus.addr_a = a;
        step();
        bus.en_a   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n       = 1'b0;
        bus.en_a      = 1'b0;
        bus.we_a      = 4'b0000;
        bus.addr_a    = 32'h0000_0000;
        bus.din_a     = 32'h0000_0000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'h00);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_rdsel", 32'(bus.mmio_rd_sel), 32'd0);
        check("rst_rdata", bus.mmio_rdata, 32'd0);

        // First AVAIL read: rd_sel for one cycle only, rdata holds afterwards
        read_addr(AVAIL);
        check("avail0_sel", 32'(bus.mmio_rd_sel), 32'd1);
        check("avail0_val", bus.mmio_rdata, 32'd16);
        check("avail0_valid", 32'(bus.out_valid), 32'd0);
        check("avail0_drop", 32'(drop_count), 32'd0);
        step();
        check("avail0_sel_drop", 32'(bus.mmio_rd_sel), 32'd0);
        check("avail0_hold", bus.mmio_rdata, 32'd16);

        // Two stores, low byte only, then partial drain
        store(DATA, 32'h0000_0041, 4'b0001);
        check("push1_valid", 32'(bus.out_valid), 32'd1);
        check("push1_data", 32'(bus.out_data), 32'h41);
        store(DATA, 32'h1234_5642, 4'b1111);
        read_addr(AVAIL);
        check("avail2", bus.mmio_rdata, 32'd14);
        check("head41", 32'(bus.out_data), 32'h41);
        bus.out_ready = 1'b1;
        check("pop41", 32'(bus.out_data), 32'h41);
        step();
        check("pop42", 32'(bus.out_data), 32'h42);
        step();
        bus.out_ready = 1'b0;
        check("empty2", 32'(bus.out_valid), 32'd0);
        read_addr(AVAIL);
        check("avail16b", bus.mmio_rdata, 32'd16);

        // Overfill: 18 stores, 2 dropped; drain wraps the pointers
        for (int i = 0; i < 18; i++) begin
            store(DATA, 32'(i), 4'b0001);
        end
        read_addr(AVAIL);
        check("avail_full", bus.mmio_rdata, 32'd0);
        check("drop2", 32'(drop_count), 32'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), 32'(bus.out_data), 32'(i));
            step();
        end
        bus.out_ready = 1'b0;
        check("drained_empty", 32'(bus.out_valid), 32'd0);

        // Full FIFO with simultaneous pop and push of 0xAA
        for (int i = 0; i < 16; i++) begin
            store(DATA, 32'h80 + 32'(i), 4'b0001);
        end
        bus.out_ready = 1'b1;
        store(DATA, 32'h0000_00AA, 4'b1111);
        bus.out_ready = 1'b0;
        check("fullpp_drop", 32'(drop_count), 32'd2);
        check("fullpp_head", 32'(bus.out_data), 32'h81);
        read_addr(AVAIL);
        check("fullpp_avail", bus.mmio_rdata, 32'd0);

        // Back-to-back AVAIL reads while popping report the pre-pop count
        bus.out_ready = 1'b1;
        bus.en_a      = 1'b1;
        bus.we_a      = 4'b0000;
        bus.addr_a    = AVAIL;
        step();
        check("b2b_sel1", 32'(bus.mmio_rd_sel), 32'd1);
        check("b2b_val1", bus.mmio_rdata, 32'd0);
        step();
        bus.en_a = 1'b0;
        check("b2b_sel2", 32'(bus.mmio_rd_sel), 32'd1);
        check("b2b_val2", bus.mmio_rdata, 32'd1);
        for (int i = 3; i < 16; i++) begin
            check($sformatf("drainb%0d", i), 32'(bus.out_data), 32'h80 + 32'(i));
            step();
        end
        check("b2b_sel_off", 32'(bus.mmio_rd_sel), 32'd0);
        check("b2b_hold", bus.mmio_rdata, 32'd1);
        check("drain_aa", 32'(bus.out_data), 32'hAA);
        step();
        bus.out_ready = 1'b0;
        check("aa_last", 32'(bus.out_valid), 32'd0);

        // Unclaimed accesses: other address, AVAIL write, DATA read, aliased low address
        store(32'h8000_0008, 32'h0000_0055, 4'b1111);
        check("nodec_valid", 32'(bus.out_valid), 32'd0);
        store(AVAIL, 32'h0000_0066, 4'b1111);
        check("wavail_valid", 32'(bus.out_valid), 32'd0);
        check("wavail_sel", 32'(bus.mmio_rd_sel), 32'd0);
        read_addr(DATA);
        check("rdata_sel", 32'(bus.mmio_rd_sel), 32'd0);
        store(32'h0000_0004, 32'h0000_0077, 4'b0001);
        check("alias_valid", 32'(bus.out_valid), 32'd0);
        read_addr(AVAIL);
        check("unclaimed_avail", bus.mmio_rdata, 32'd16);

        // Reset mid-drain with 5 bytes queued
        for (int i = 0; i < 6; i++) begin
            store(DATA, 32'h30 + 32'(i), 4'b0001);
        end
        bus.out_ready = 1'b1;
        check("mid_head0", 32'(bus.out_data), 32'h30);
        step();
        check("mid_head1", 32'(bus.out_data), 32'h31);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", 32'(bus.out_valid), 32'd0);
        check("async_data", 32'(bus.out_data), 32'h00);
        bus.out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("post_rst_sel", 32'(bus.mmio_rd_sel), 32'd0);
        read_addr(AVAIL);
        check("post_rst_avail", bus.mmio_rdata, 32'd16);
        check("post_rst_drop", 32'(drop_count), 32'd0);
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_output_buffer.md
# mmio_output_buffer

Memory-mapped output byte FIFO that sits beside `NewUnifiedMemory` on general-purpose port A and implements the two output registers that memory deliberately ignores. It captures bytes stored to 0x8000_0004 and answers loads of 0x8000_0000 with the current free space. It drains captured bytes to the host-side consumer over a valid/ready byte stream. The core muxes `mmio_rdata` over the memory's `dout_a` whenever `mmio_rd_sel` is high.

## Interface

Parameters:
- DEPTH, 16, FIFO capacity in bytes; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, width of occupancy/free counters

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- en_a  in  1  port A access enable (same signal driven to memory)
- we_a  in  4  port A byte write enables
- addr_a  in  32  port A byte address
- din_a  in  32  port A write data
- mmio_rd_sel  out  1  registered; high when the current `dout_a` cycle belongs to this block
- mmio_rdata  out  32  registered read data for 0x8000_0000
- out_data  out  8  head byte of FIFO
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts `out_data` this cycle
- drop_count  out  8  saturating count of bytes discarded on full

## Operation

- Decode uses the full 32-bit address: AVAIL = 0x8000_0000, DATA = 0x8000_0004. No partial decode and no aliasing.
- Push: `en_a` && `we_a != 0` && `addr_a == DATA`. `din_a[7:0]` is enqueued regardless of which `we_a` bits are set.
- Read: `en_a` && `we_a == 0` && `addr_a == AVAIL`.
  - Next edge: `mmio_rd_sel` <= 1 and `mmio_rdata` <= {zero-extend, DEPTH − count}.
  - `count` is the value before this edge's push/pop.
  - Every other edge sets `mmio_rd_sel` <= 0; `mmio_rdata` holds its value.
- Writes to AVAIL have no effect. Reads of DATA are not claimed: `mmio_rd_sel` stays 0 and the memory's undefined value passes through.
- Pop: `out_valid && out_ready`. The head pointer advances.
- FIFO storage:
  - circular buffer with wrap-around pointers `wr_ptr` and `rd_ptr` (log2 DEPTH bits)
  - `count` of CNT_W bits
- Push while full:
  - With a simultaneous pop: the push is accepted and `count` is unchanged.
  - Otherwise: the byte is discarded and `drop_count` increments, saturating at 255.
- Simultaneous push and pop when `count` is neither 0 nor DEPTH: both occur and `count` is unchanged.
- Push into an empty FIFO never bypasses to `out_data` in the same cycle.
- Count update: `count` <= `count` + push_ok − pop.

## Timing

- Reset (async assert, sync release by the system):
  - `count`, pointers, `drop_count`, `mmio_rd_sel`, `mmio_rdata` = 0
  - `out_valid` = 0
  - `out_data` = 0
  - FIFO contents are don't-care
- Reset mid-operation discards all buffered bytes immediately. No pop is reported.
- Read latency is 1 edge, matching memory: a request sampled at edge N gives `mmio_rdata`/`mmio_rd_sel` valid after N, for cycle N+1 only.
- Push-to-visible latency is 1 edge: a byte pushed at edge N gives `out_valid` = 1 and `out_data` = byte after N.
- `out_valid`/`out_data` are combinational from registered state only (`count`, head entry). No path from `out_ready` to `out_valid`.
- `out_data` is stable while `out_valid && !out_ready`.
- Throughput is 1 push and 1 pop per cycle sustained.
- Back-to-back AVAIL reads return the free space as it stood at each request edge.

## Test plan

- Reset, then read AVAIL with `out_ready` = 0: `mmio_rd_sel` = 1 for one cycle, `mmio_rdata` = 16, `out_valid` = 0, `drop_count` = 0.
- Store 0x41 (`we_a` = 0001), then 0x1234_5642 (`we_a` = 1111), to DATA with `out_ready` = 0; read AVAIL: returns 14; `out_data` = 0x41. Raise `out_ready` for 2 cycles: sees 0x41 then 0x42; `out_valid` drops; AVAIL read = 16.
- 18 stores of bytes 0..17 with `out_ready` = 0: AVAIL = 0, `drop_count` = 2. Drain: exactly bytes 0..15 in order, across a pointer wrap after a prior partial drain.
- FIFO full, `out_ready` = 1 with a same-cycle store of 0xAA: `count` stays 16, `drop_count` unchanged, 0xAA emerges last.
- Store to 0x8000_0008, write to AVAIL, read DATA: no push, `mmio_rd_sel` stays 0, `count` unchanged.
- Assert `reset_n` low mid-drain with 5 bytes queued: `out_valid` falls asynchronously. After release, AVAIL = 16 and `drop_count` = 0.
